// File: rtl/qnn_pkg.sv
// Shared definitions for the quantised network layers: widths, FSM states,
// FC2 geometry and the 16-bit saturation helper.
`default_nettype none

package qnn_pkg;
  localparam int ACT_W          = 16;
  localparam int WGT_W          = 8;
  localparam int FC2_ACC_W      = 28;
  localparam int FC2_SHIFT      = 8;
  localparam int FC2_INPUT_NUM  = 16;
  localparam int FC2_OUTPUT_NUM = 10;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_MAC    = 3'd1;
  localparam state_t ST_BIAS   = 3'd2;
  localparam state_t ST_ARGMAX = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam logic signed [FC2_ACC_W-1:0] SAT_HI = 28'sd32767;
  localparam logic signed [FC2_ACC_W-1:0] SAT_LO = -28'sd32768;

  function automatic logic signed [ACT_W-1:0] sat16(input logic signed [FC2_ACC_W-1:0] v);
    if (v > SAT_HI)      sat16 = 16'sh7FFF;
    else if (v < SAT_LO) sat16 = 16'sh8000;
    else                 sat16 = v[ACT_W-1:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/argmax_seq.sv
// Sequential arg-max over N packed signed logits, one per cycle after start_i.
// Strict greater-than comparison, so the lowest index wins ties.
`default_nettype none

module argmax_seq
  import qnn_pkg::*;
#(
  parameter int N = FC2_OUTPUT_NUM
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [N*ACT_W-1:0]   logits_i,
  output logic                 done_o,
  output logic [3:0]           class_o,
  output logic [ACT_W-1:0]     max_o
);
  logic                    active_q;
  logic [3:0]              j_q;
  logic [3:0]              cls_q;
  logic signed [ACT_W-1:0] max_q;
  logic signed [ACT_W-1:0] cur;

  assign cur     = $signed(logits_i[ACT_W*j_q +: ACT_W]);
  // High during the cycle in which the final index is being compared.
  assign done_o  = active_q && (j_q == 4'(N-1));
  assign class_o = cls_q;
  assign max_o   = max_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      j_q      <= '0;
      cls_q    <= '0;
      max_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      j_q      <= '0;
    end else if (active_q) begin
      if ((j_q == 4'd0) || (cur > max_q)) begin
        cls_q <= j_q;
        max_q <= cur;
      end
      if (done_o) active_q <= 1'b0;
      else        j_q      <= j_q + 4'd1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/fc2_classifier.sv
// 16->10 int8 FC layer with byte-serial weight load and sequential arg-max.
// Optional macro FC2_LOGIT_OUT_EN exposes all ten saturated logits on o_logits.
`default_nettype none

module fc2_classifier
  import qnn_pkg::*;
#(
  parameter int INPUT_NUM  = FC2_INPUT_NUM,
  parameter int OUTPUT_NUM = FC2_OUTPUT_NUM,
  parameter int ACC_W      = FC2_ACC_W,
  parameter int SHIFT      = FC2_SHIFT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        weight_valid,
  input  logic [7:0]  filter,
  input  logic        i_valid,
  input  logic [15:0] data_in_1,  input logic [15:0] data_in_2,
  input  logic [15:0] data_in_3,  input logic [15:0] data_in_4,
  input  logic [15:0] data_in_5,  input logic [15:0] data_in_6,
  input  logic [15:0] data_in_7,  input logic [15:0] data_in_8,
  input  logic [15:0] data_in_9,  input logic [15:0] data_in_10,
  input  logic [15:0] data_in_11, input logic [15:0] data_in_12,
  input  logic [15:0] data_in_13, input logic [15:0] data_in_14,
  input  logic [15:0] data_in_15, input logic [15:0] data_in_16,
  output logic        weight_done,
  output logic        o_busy,
  output logic        o_valid,
  output logic [3:0]  o_class,
  output logic [15:0] o_max
`ifdef FC2_LOGIT_OUT_EN
  ,
  output logic [OUTPUT_NUM*16-1:0] o_logits
`endif
);
  localparam int NW   = INPUT_NUM * OUTPUT_NUM;
  localparam int NTOT = NW + OUTPUT_NUM;
  localparam int CW   = $clog2(NTOT + 1);
  localparam int KW   = $clog2(INPUT_NUM);
  localparam int BW   = $clog2(OUTPUT_NUM);

  logic signed [WGT_W-1:0]  w_q [NW];
  logic signed [WGT_W-1:0]  b_q [OUTPUT_NUM];
  logic [CW-1:0]            load_cnt_q;
  logic                     weight_done_q;
  logic [BW-1:0]            b_idx;

  logic signed [ACT_W-1:0]  x_in [INPUT_NUM];
  logic signed [ACT_W-1:0]  x_q  [INPUT_NUM];
  logic signed [ACC_W-1:0]  acc_q [OUTPUT_NUM];
  logic signed [ACC_W-1:0]  acc_d [OUTPUT_NUM];
  logic [OUTPUT_NUM*ACT_W-1:0] logit_q, logit_d;
  logic [KW-1:0]            k_q;
  state_t                   state_q, state_d;
  logic                     busy_q, valid_q;
  logic [3:0]               class_q;
  logic [ACT_W-1:0]         max_q;
  logic                     accept, am_done;
  logic [3:0]               am_class;
  logic [ACT_W-1:0]         am_max;

  assign x_in[0]  = data_in_1;  assign x_in[1]  = data_in_2;
  assign x_in[2]  = data_in_3;  assign x_in[3]  = data_in_4;
  assign x_in[4]  = data_in_5;  assign x_in[5]  = data_in_6;
  assign x_in[6]  = data_in_7;  assign x_in[7]  = data_in_8;
  assign x_in[8]  = data_in_9;  assign x_in[9]  = data_in_10;
  assign x_in[10] = data_in_11; assign x_in[11] = data_in_12;
  assign x_in[12] = data_in_13; assign x_in[13] = data_in_14;
  assign x_in[14] = data_in_15; assign x_in[15] = data_in_16;

  assign b_idx  = BW'(load_cnt_q - CW'(NW));
  assign accept = (state_q == ST_IDLE) && weight_done_q && i_valid;

  // The load counter freezes once the last bias byte is in; later bytes are dropped.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NW; i++)         w_q[i] <= '0;
      for (int i = 0; i < OUTPUT_NUM; i++) b_q[i] <= '0;
      load_cnt_q    <= '0;
      weight_done_q <= 1'b0;
    end else if (weight_valid && !weight_done_q) begin
      if (load_cnt_q < CW'(NW)) w_q[load_cnt_q] <= filter;
      else                      b_q[b_idx]      <= filter;
      load_cnt_q    <= load_cnt_q + 1'b1;
      weight_done_q <= (load_cnt_q == CW'(NTOT - 1));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_MAC;
      ST_MAC:    if (k_q == KW'(INPUT_NUM - 1)) state_d = ST_BIAS;
      ST_BIAS:   state_d = ST_ARGMAX;
      ST_ARGMAX: if (am_done) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    logic signed [ACT_W+WGT_W-1:0] prod;
    logic signed [ACC_W-1:0]       biased;
    logic [CW-1:0]                 wi;
    logit_d = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      wi       = CW'(o * INPUT_NUM) + CW'(k_q);
      prod     = 24'(24'(x_q[k_q]) * 24'(w_q[wi]));
      acc_d[o] = acc_q[o] + ACC_W'(prod);
      biased   = acc_q[o] + ACC_W'(b_q[o]);
      logit_d[ACT_W*o +: ACT_W] = sat16(biased >>> SHIFT);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      for (int i = 0; i < INPUT_NUM; i++)  x_q[i]   <= '0;
      for (int o = 0; o < OUTPUT_NUM; o++) acc_q[o] <= '0;
      logit_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      class_q <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          x_q    <= x_in;
          for (int o = 0; o < OUTPUT_NUM; o++) acc_q[o] <= '0;
          k_q    <= '0;
          busy_q <= 1'b1;
        end
        ST_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
        end
        ST_BIAS: logit_q <= logit_d;
        ST_DONE: begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          class_q <= am_class;
          max_q   <= am_max;
        end
        default: ;
      endcase
    end
  end

  argmax_seq #(.N(OUTPUT_NUM)) u_argmax (
    .clk_i    (i_clk),
    .rst_ni   (i_rst),
    .start_i  (state_q == ST_BIAS),
    .logits_i (logit_q),
    .done_o   (am_done),
    .class_o  (am_class),
    .max_o    (am_max)
  );

  assign weight_done = weight_done_q;
  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_class     = class_q;
  assign o_max       = max_q;
`ifdef FC2_LOGIT_OUT_EN
  assign o_logits    = logit_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_fc2_classifier.sv
// Scoreboard bench for fc2_classifier: an arithmetic reference model predicts
// class, winning logit and arrival cycle; a monitor checks every o_valid.
`default_nettype none
`timescale 1ns/1ps

module tb_fc2_classifier;
  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              weight_valid = 1'b0;
  logic [7:0]        filter = '0;
  logic              i_valid = 1'b0;
  logic [15:0]       din [16];
  logic              weight_done, o_busy, o_valid;
  logic [3:0]        o_class;
  logic signed [15:0] o_max;
`ifdef FC2_LOGIT_OUT_EN
  logic [159:0]      o_logits;
`endif

  fc2_classifier dut (
    .i_clk(i_clk), .i_rst(i_rst), .weight_valid(weight_valid), .filter(filter),
    .i_valid(i_valid),
    .data_in_1(din[0]),   .data_in_2(din[1]),   .data_in_3(din[2]),   .data_in_4(din[3]),
    .data_in_5(din[4]),   .data_in_6(din[5]),   .data_in_7(din[6]),   .data_in_8(din[7]),
    .data_in_9(din[8]),   .data_in_10(din[9]),  .data_in_11(din[10]), .data_in_12(din[11]),
    .data_in_13(din[12]), .data_in_14(din[13]), .data_in_15(din[14]), .data_in_16(din[15]),
    .weight_done(weight_done), .o_busy(o_busy), .o_valid(o_valid),
    .o_class(o_class), .o_max(o_max)
`ifdef FC2_LOGIT_OUT_EN
    , .o_logits(o_logits)
`endif
  );

  always #5 i_clk = ~i_clk;

  longint cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  typedef struct { int cls; int mx; longint at; } exp_t;
  exp_t sb[$];

  int wm [160];
  int bm [10];

  // Reference: plain integer dot products, floor-shift, clamp, first maximum wins.
  task automatic expect_result(input int x[16]);
    int acc, lg, best_c, best_v;
    best_c = 0; best_v = 0;
    for (int o = 0; o < 10; o++) begin
      acc = bm[o];
      for (int i = 0; i < 16; i++) acc += x[i] * wm[o*16+i];
      lg = acc >>> 8;
      if (lg > 32767)  lg = 32767;
      if (lg < -32768) lg = -32768;
      if (o == 0 || lg > best_v) begin best_v = lg; best_c = o; end
    end
    sb.push_back('{best_c, best_v, cyc + 1 + 28});
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst && o_valid) begin
      if (sb.size() == 0) check("spurious_o_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("o_class", int'(o_class), e.cls);
        check("o_max", int'(o_max), e.mx);
        check("latency_cycle", int'(cyc), int'(e.at));
        check("o_busy_at_valid", int'(o_busy), 0);
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic fire(input int x[16], input bit acc_exp);
    for (int i = 0; i < 16; i++) din[i] = 16'(x[i]);
    i_valid = 1'b1;
    if (acc_exp) expect_result(x);
    @(negedge i_clk);
    i_valid = 1'b0;
    if (acc_exp) check("o_busy_after_accept", int'(o_busy), 1);
  endtask

  task automatic reset_now();
    i_rst = 1'b0;
    sb.delete();
    #1;
    check("rst_weight_done", int'(weight_done), 0);
    check("rst_o_busy", int'(o_busy), 0);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_class", int'(o_class), 0);
    check("rst_o_max", int'(o_max), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    reset_now();
  endtask

  task automatic load_range(input int lo, input int hi);
    for (int n = lo; n < hi; n++) begin
      @(negedge i_clk);
      weight_valid = 1'b1;
      if (n < 160) filter = 8'(wm[n]);
      else         filter = 8'(bm[n-160]);
      if (n == 169) check("weight_done_before_last", int'(weight_done), 0);
    end
    @(negedge i_clk);
    weight_valid = 1'b0;
    if (hi == 170) check("weight_done_after_last", int'(weight_done), 1);
  endtask

  task automatic load_all();
    load_range(0, 170);
    weight_valid = 1'b1;
    filter = 8'hA5;
    repeat (2) @(negedge i_clk);
    weight_valid = 1'b0;
    check("weight_done_hold", int'(weight_done), 1);
  endtask

  task automatic set_all(input int wv, input int bv);
    for (int n = 0; n < 160; n++) wm[n] = wv;
    for (int n = 0; n < 10; n++)  bm[n] = bv;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge i_clk); t++; end
    @(negedge i_clk);
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!o_valid && t < 60) begin @(negedge i_clk); t++; end
    check("valid_seen", int'(o_valid), 1);
  endtask

  function automatic int rs16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int xa[16], xb[16];
    for (int i = 0; i < 16; i++) din[i] = '0;
    apply_reset();

    // Uniform weights: every logit 16, class 0.
    set_all(1, 0);
    load_all();
    for (int i = 0; i < 16; i++) xa[i] = 256;
    fire(xa, 1);
    wait_drain();

    // Row 7 doubled, then a large bias on class 3 that must not overtake it.
    apply_reset();
    for (int i = 0; i < 16; i++) wm[7*16+i] = 2;
    load_all();
    fire(xa, 1);
    wait_drain();
    apply_reset();
    bm[3] = 127;
    load_all();
    fire(xa, 1);
    wait_drain();

    // Positive and negative saturation, all tied -> class 0.
    apply_reset();
    set_all(127, 0);
    load_all();
    for (int i = 0; i < 16; i++) xa[i] = 32767;
    fire(xa, 1);
    wait_drain();
    apply_reset();
    set_all(-128, 0);
    load_all();
    fire(xa, 1);
    wait_drain();

    // Pulses before load completes and during MAC are dropped.
    apply_reset();
    set_all(1, 0);
    for (int i = 0; i < 16; i++) begin xa[i] = 256; xb[i] = 256 * i; end
    load_range(0, 100);
    fire(xa, 0);
    load_range(100, 170);
    repeat (35) @(negedge i_clk);
    fire(xa, 1);
    repeat (3) @(negedge i_clk);
    fire(xb, 0);
    wait_drain();
    repeat (35) @(negedge i_clk);

    // Reset during MAC cycle 5 aborts, then reload and rerun.
    apply_reset();
    for (int n = 0; n < 160; n++) wm[n] = int'($urandom_range(0, 255)) - 128;
    load_all();
    for (int i = 0; i < 16; i++) xa[i] = rs16();
    fire(xa, 1);
    repeat (4) @(negedge i_clk);
    reset_now();
    repeat (40) @(negedge i_clk);
    load_all();
    fire(xa, 1);
    wait_drain();

    // Back-to-back: second request issued in the o_valid cycle.
    for (int i = 0; i < 16; i++) xb[i] = rs16();
    fire(xa, 1);
    wait_valid();
    fire(xb, 1);
    wait_drain();

    // Randomised weights/inputs; odd rounds use coarse values to force ties.
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      for (int n = 0; n < 160; n++)
        wm[n] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 2));
      for (int n = 0; n < 10; n++)
        bm[n] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : 0;
      load_all();
      for (int q = 0; q < 3; q++) begin
        for (int i = 0; i < 16; i++)
          xa[i] = (r % 2 == 0) ? rs16() : 256 * int'($urandom_range(0, 2));
        fire(xa, 1);
        wait_valid();
        repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
